lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 187 ++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//
// Purpose:
//   Load/store unit bus master. It takes one byte/half/word request from the
//   core and issues a single-cycle access to a word-addressed memory with
//   byte enables. It waits for the memory acknowledge, or gives up after
//   TIMEOUT cycles. It then returns one response pulse with extended load
//   data and an error flag. Misaligned and illegal-size requests are answered
//   with an error and never reach the bus.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid / req_ready  request handshake (ready only when idle)
//   req_we                 1 = store, 0 = load
//   req_size               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned           zero-extend loads when 1, sign-extend when 0
//   req_addr, req_wdata    byte address and LSB-aligned store data
//   resp_valid             one-cycle response pulse
//   resp_rdata, resp_err   load data / error, zero outside the pulse
//   bus_sel, bus_we        memory strobe and write enable (ISSUE only)
//   bus_byte_en            byte lanes written by a store
//   bus_addr, bus_din      word address and replicated store data
//   bus_dout, bus_ack      read data and acknowledge from memory
// ---------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  bus_sel,
    output logic                  bus_we,
    output logic [3:0]            bus_byte_en,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_din,
    input  logic [31:0]           bus_dout,
    input  logic                  bus_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    state_t                state, state_next;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic [7:0]            cnt_q;

    logic                  illegal;
    logic                  timeout_hit;
    logic                  bus_active;
    logic [1:0]            lane;
    logic [31:0]           shifted;
    logic [31:0]           load_ext;

    // Upper address bits lie outside the memory and are deliberately dropped.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign illegal = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign timeout_hit = (cnt_q + 8'd1) == TIMEOUT_CNT;
    assign lane        = addr_q[1:0];
    assign bus_active  = (state == ISSUE) || (state == WAIT);

    // Bring the addressed lane down to bit 0, then extend byte/half results.
    assign shifted = bus_dout >> {lane, 3'b000};
    always_comb begin
        load_ext = bus_dout;
        case (size_q)
            2'b00:   load_ext = unsigned_q ? {24'b0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = unsigned_q ? {16'b0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = bus_dout;
        endcase
    end

    // State register and request/response datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'b0;
            rdata_q    <= 32'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        addr_q     <= req_addr[ADDR_WIDTH+1:0];
                        wdata_q    <= req_wdata;
                        err_q      <= illegal;
                        rdata_q    <= 32'b0;
                        cnt_q      <= 8'd0;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        rdata_q <= we_q ? 32'b0 : load_ext;
                        err_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (timeout_hit) begin
                            rdata_q <= 32'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    rdata_q <= 32'b0;
                    err_q   <= 1'b0;
                    cnt_q   <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; bus_ack only matters while waiting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = illegal ? RESP : ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (bus_ack || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus and response outputs, all decoded from state so reset clears them
    // immediately.
    always_comb begin
        req_ready   = (state == IDLE);
        bus_sel     = (state == ISSUE);
        bus_we      = (state == ISSUE) && we_q;
        bus_addr    = '0;
        bus_byte_en = 4'b0000;
        bus_din     = 32'b0;
        resp_valid  = (state == RESP);
        resp_rdata  = (state == RESP) ? rdata_q : 32'b0;
        resp_err    = (state == RESP) && err_q;
        if (bus_active) begin
            bus_addr = addr_q[ADDR_WIDTH+1:2];
            case (size_q)
                2'b00:   bus_din = {4{wdata_q[7:0]}};
                2'b01:   bus_din = {2{wdata_q[15:0]}};
                default: bus_din = wdata_q;
            endcase
            if (we_q) begin
                case (size_q)
                    2'b00:   bus_byte_en = 4'b0001 << lane;
                    2'b01:   bus_byte_en = 4'b0011 << lane;
                    default: bus_byte_en = 4'b1111;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_master
//
// Purpose:
//   Directed testbench for lsu_mem_master. A behavioural memory answers each
//   bus access one cycle after ISSUE. A table of requests with hand-computed
//   results is run in order. Hand-written sequences then cover reset, timeout
//   with a stray acknowledge, and reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_lsu_mem_master;

    localparam int AW = 10;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          bus_sel;
    logic          bus_we;
    logic [3:0]    bus_byte_en;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_din;
    logic [31:0]   bus_dout = 32'h5A5A5A5A;
    logic          bus_ack;

    logic          mem_ack     = 1'b0;
    logic          stray_ack   = 1'b0;
    logic          mem_en      = 1'b1;
    logic          ack_pending = 1'b0;
    logic          mem_cleared = 1'b0;
    logic [AW-1:0] pend_addr   = '0;
    logic [31:0]   mem [0:(1<<AW)-1];

    int tests_run = 0;
    int tests_failed = 0;

    assign bus_ack = mem_ack | stray_ack;

    lsu_mem_master #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .bus_sel      (bus_sel),
        .bus_we       (bus_we),
        .bus_byte_en  (bus_byte_en),
        .bus_addr     (bus_addr),
        .bus_din      (bus_din),
        .bus_dout     (bus_dout),
        .bus_ack      (bus_ack)
    );

    always #5 clk = ~clk;

    // Memory model: a strobe seen during ISSUE performs the write at once,
    // and the acknowledge with read data follows on the next cycle.
    always @(negedge clk) begin
        if (!mem_cleared) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] = 32'b0;
            mem_cleared = 1'b1;
        end
        mem_ack  = 1'b0;
        bus_dout = 32'h5A5A5A5A;
        if (ack_pending) begin
            mem_ack     = 1'b1;
            bus_dout    = mem[pend_addr];
            ack_pending = 1'b0;
        end
        if (bus_sel && mem_en) begin
            if (bus_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus_byte_en[b]) mem[bus_addr][8*b +: 8] = bus_din[8*b +: 8];
            end
            ack_pending = 1'b1;
            pend_addr   = bus_addr;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_sel;
        logic [3:0]  exp_be;
        logic [9:0]  exp_baddr;
        logic [31:0] exp_din;
        int          exp_lat;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_err, input logic [31:0] exp_rdata,
                                input int exp_sel, input logic [3:0] exp_be,
                                input logic [9:0] exp_baddr, input logic [31:0] exp_din,
                                input int exp_lat);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_sel = exp_sel;
        v.exp_be = exp_be; v.exp_baddr = exp_baddr; v.exp_din = exp_din;
        v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one request and records what the bus and response looked like.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int sel_cnt, output logic [3:0] be,
                                 output logic [9:0] baddr, output logic we_seen,
                                 output logic [31:0] din, output logic [31:0] rdata,
                                 output logic err, output int lat, output logic leak);
        sel_cnt = 0; be = 4'b0; baddr = 10'b0; we_seen = 1'b0; din = 32'b0;
        rdata = 32'hBAD0BAD0; err = 1'bx; lat = 0; leak = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = ~we; req_size = 2'b11; req_unsigned = ~uns;
        req_addr = 32'hFFFFFFFF; req_wdata = 32'h0F0F0F0F;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus_sel) begin
                sel_cnt++; be = bus_byte_en; baddr = bus_addr; we_seen = bus_we; din = bus_din;
            end else if (sel_cnt > 0 && !resp_valid && (bus_addr != baddr || bus_we)) begin
                leak = 1'b1;
            end
            if (resp_valid) begin
                rdata = resp_rdata; err = resp_err; lat = c;
                break;
            end else if (resp_rdata != 32'b0 || resp_err) begin
                leak = 1'b1;
            end
        end
    endtask

    initial begin
        int          sel_cnt, lat;
        logic [3:0]  be;
        logic [9:0]  baddr;
        logic        we_seen, err, leak, flag;
        logic [31:0] din, rdata;

        vecs[0]  = mk(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        1, 4'hF, 10'd4, 32'hDEADBEEF, 3);
        vecs[1]  = mk(1, 2'b00, 0, 32'h13, 32'h000000AB, 0, 32'h0,        1, 4'h8, 10'd4, 32'hABABABAB, 3);
        vecs[2]  = mk(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hABADBEEF, 1, 4'h0, 10'd4, 32'h0,        3);
        vecs[3]  = mk(0, 2'b00, 0, 32'h13, 32'h0,        0, 32'hFFFFFFAB, 1, 4'h0, 10'd4, 32'h0,        3);
        vecs[4]  = mk(0, 2'b00, 1, 32'h13, 32'h0,        0, 32'h000000AB, 1, 4'h0, 10'd4, 32'h0,        3);
        vecs[5]  = mk(0, 2'b01, 0, 32'h12, 32'h0,        0, 32'hFFFFABAD, 1, 4'h0, 10'd4, 32'h0,        3);
        vecs[6]  = mk(0, 2'b01, 1, 32'h10, 32'h0,        0, 32'h0000BEEF, 1, 4'h0, 10'd4, 32'h0,        3);
        vecs[7]  = mk(0, 2'b00, 0, 32'h10, 32'h0,        0, 32'hFFFFFFEF, 1, 4'h0, 10'd4, 32'h0,        3);
        vecs[8]  = mk(1, 2'b01, 0, 32'h22, 32'h00001234, 0, 32'h0,        1, 4'hC, 10'd8, 32'h12341234, 3);
        vecs[9]  = mk(1, 2'b00, 0, 32'h21, 32'h0000007F, 0, 32'h0,        1, 4'h2, 10'd8, 32'h7F7F7F7F, 3);
        vecs[10] = mk(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h12347F00, 1, 4'h0, 10'd8, 32'h0,        3);
        vecs[11] = mk(0, 2'b00, 0, 32'h21, 32'h0,        0, 32'h0000007F, 1, 4'h0, 10'd8, 32'h0,        3);
        vecs[12] = mk(0, 2'b01, 0, 32'h11, 32'h0,        1, 32'h0,        0, 4'h0, 10'd0, 32'h0,        1);
        vecs[13] = mk(0, 2'b11, 0, 32'h20, 32'h0,        1, 32'h0,        0, 4'h0, 10'd0, 32'h0,        1);
        vecs[14] = mk(1, 2'b10, 0, 32'h12, 32'hDEADBEEF, 1, 32'h0,        0, 4'h0, 10'd0, 32'h0,        1);
        vecs[15] = mk(0, 2'b01, 0, 32'h20, 32'h0,        0, 32'h00007F00, 1, 4'h0, 10'd8, 32'h0,        3);

        // Reset state.
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp", {resp_rdata[30:0] | {30'b0, resp_valid}, resp_err}, 32'd0);
        checkOutput("rst_bus_ctl", {26'b0, bus_sel, bus_we, bus_byte_en}, 32'd0);
        checkOutput("rst_bus_data", bus_din | {22'b0, bus_addr}, 32'd0);
        rst_n = 1'b1;

        // Table of requests.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                          sel_cnt, be, baddr, we_seen, din, rdata, err, lat, leak);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d_sel_cycles", i), sel_cnt, vecs[i].exp_sel);
            checkOutput($sformatf("v%0d_bus_we", i), {31'b0, we_seen},
                        {31'b0, vecs[i].we && vecs[i].exp_sel == 1});
            checkOutput($sformatf("v%0d_byte_en", i), {28'b0, be}, {28'b0, vecs[i].exp_be});
            checkOutput($sformatf("v%0d_bus_addr", i), {22'b0, baddr}, {22'b0, vecs[i].exp_baddr});
            checkOutput($sformatf("v%0d_bus_din", i), din, vecs[i].exp_din);
            checkOutput($sformatf("v%0d_quiet", i), {31'b0, leak}, 32'd0);
        end

        // Timeout with no acknowledge, then a stray acknowledge while idle.
        mem_en = 1'b0;
        applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, sel_cnt, be, baddr, we_seen, din, rdata, err, lat, leak);
        checkOutput("to_latency", lat, TO + 2);
        checkOutput("to_err", {31'b0, err}, 32'd1);
        checkOutput("to_rdata", rdata, 32'd0);
        checkOutput("to_quiet", {31'b0, leak}, 32'd0);
        @(negedge clk);
        stray_ack = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid || !req_ready || bus_sel) flag = 1'b1;
        end
        stray_ack = 1'b0;
        checkOutput("stray_ack_ignored", {31'b0, flag}, 32'd0);
        mem_en = 1'b1;
        applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, sel_cnt, be, baddr, we_seen, din, rdata, err, lat, leak);
        checkOutput("after_to_rdata", rdata, 32'hABADBEEF);
        checkOutput("after_to_latency", lat, 3);

        // Reset during ISSUE drops the strobes at once.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h11111111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checkOutput("issue_sel", {30'b0, bus_sel, bus_we}, 32'd3);
        rst_n = 1'b0;
        #1;
        checkOutput("issue_rst_drop", {29'b0, bus_sel, bus_we, req_ready}, 32'd1);
        flag = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) flag = 1'b1;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) flag = 1'b1;
        end
        checkOutput("issue_rst_no_resp", {31'b0, flag}, 32'd0);

        // Reset during WAIT abandons the access; the next request still works.
        mem_en = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("wait_rst_ready", {30'b0, req_ready, bus_sel}, 32'd2);
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) flag = 1'b1;
        end
        rst_n = 1'b1;
        mem_en = 1'b1;
        checkOutput("wait_rst_no_resp", {31'b0, flag}, 32'd0);
        applyStimulus(0, 2'b00, 1, 32'h13, 32'h0, sel_cnt, be, baddr, we_seen, din, rdata, err, lat, leak);
        checkOutput("post_rst_rdata", rdata, 32'h000000AB);
        checkOutput("post_rst_err", {31'b0, err}, 32'd0);
        checkOutput("post_rst_latency", lat, 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
